count_alarm: RTL

//   Timed-event generator sitting directly downstream of the free-running counter; consumes its count value.

---
 rtl/count_alarm_pkg.sv | 14 +
 rtl/count_alarm.sv | 130 +++++++++++++
 2 files changed

// File: rtl/count_alarm_pkg.sv
// Shared types for the count_alarm timed-event generator.
//   count_alarm_state_t : alarm controller state
//     IDLE  - disarmed, accepting a new arm request
//     ARMED - waiting for the count to advance by the programmed delay
//     DRAIN - disarmed, still holding an event that downstream has not taken
package count_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } count_alarm_state_t;

endpackage

// File: rtl/count_alarm.sv
// count_alarm
//   Timed-event generator fed by a free-running counter. Upstream arms a
//   one-shot or periodic alarm with a delay. The block raises a time-stamped
//   event once the count has advanced by that many ticks. The comparison uses
//   the modular difference (count - start), so it stays correct across the
//   2^WIDTH wrap.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid && ready are both high. A producer holds its payload stable while
//   valid is high and ready is low. o_req_ready does not depend on
//   i_req_valid. The event slot never withdraws o_evt_valid before it is
//   accepted.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_count   [WIDTH]     free-running count (advances 0 or 1 per cycle)
//   i_req_valid/o_req_ready, i_req_delay [WIDTH], i_req_periodic
//                         arm request; a delay of 0 behaves as 1
//   i_cancel              disarm; only acts while ARMED
//   o_evt_valid/i_evt_ready, o_evt_stamp [WIDTH]
//                         expiry event, stamped with i_count at detection
//   o_busy                controller not IDLE
//   o_missed  [MISS_W]    periodic expiries dropped because the slot was full
//                         (saturating)
module count_alarm
    import count_alarm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MISS_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_count,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [WIDTH-1:0]  i_req_delay,
    input  logic              i_req_periodic,
    input  logic              i_cancel,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [WIDTH-1:0]  o_evt_stamp,
    output logic              o_busy,
    output logic [MISS_W-1:0] o_missed
);

    count_alarm_state_t r_state;
    logic [WIDTH-1:0]   r_start;
    logic [WIDTH-1:0]   r_dly;
    logic               r_per;
    logic               r_evt_valid;
    logic [WIDTH-1:0]   r_evt_stamp;
    logic [MISS_W-1:0]  r_missed;

    logic [WIDTH-1:0]   w_elapsed;
    logic [WIDTH-1:0]   w_req_dly;
    logic               w_expire;
    logic               w_accept;
    logic               w_slot_free;
    logic               w_miss_sat;

    // Modular elapsed ticks since the (re)arm point; wrap of i_count cancels out.
    assign w_elapsed   = i_count - r_start;
    assign w_expire    = (r_state == ARMED) && (w_elapsed >= r_dly);
    assign w_accept    = r_evt_valid && i_evt_ready;
    // The slot can take a new event if it is empty or is being emptied now.
    assign w_slot_free = !r_evt_valid || i_evt_ready;
    assign w_miss_sat  = &r_missed;
    assign w_req_dly   = (i_req_delay == '0) ? WIDTH'(1) : i_req_delay;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_start     <= '0;
            r_dly       <= '0;
            r_per       <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_stamp <= '0;
            r_missed    <= '0;
        end else begin
            // Accept clears the slot; an expiry below may reload it this cycle.
            if (w_accept) begin
                r_evt_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_start  <= i_count;
                        r_dly    <= w_req_dly;
                        r_per    <= i_req_periodic;
                        r_missed <= '0;
                        r_state  <= ARMED;
                    end
                end
                ARMED: begin
                    // Cancel takes priority over a coincident expiry.
                    if (i_cancel) begin
                        r_state <= w_slot_free ? IDLE : DRAIN;
                    end else if (w_expire) begin
                        if (w_slot_free) begin
                            r_evt_valid <= 1'b1;
                            r_evt_stamp <= i_count;
                        end else if (!w_miss_sat) begin
                            r_missed <= r_missed + MISS_W'(1);
                        end
                        if (r_per) begin
                            // Advance from the previous deadline, not from now, so
                            // the period never drifts.
                            r_start <= r_start + r_dly;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_evt_valid = r_evt_valid;
    assign o_evt_stamp = r_evt_stamp;
    assign o_missed    = r_missed;

endmodule
